// File: rtl/uart_tx_fifo_drain.sv
// Pops the UART TX FIFO one byte at a time and serializes each byte as start/8 data LSB-first/parity/stop bits.
// Tx falls 3 cycles after Empty is seen low in IDLE; FIFO flags are only sampled in IDLE, so a frame is never interrupted.
module uart_tx_fifo_drain #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Enable,
   input  logic [3:0] Fifo_Status,
   input  logic [7:0] Fifo_Data,
   output logic       Read,
   output logic       Tx,
   output logic       Busy,
   output logic       Tx_Done
);

   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PENULT = BW'(CLKS_PER_BIT - 2);
   localparam logic [2:0]    STOP_LAST   = 3'(STOP_BITS - 1);
   localparam logic          PAR_ODD     = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
   } state_t;

   state_t          state;
   logic [BW-1:0]   baud;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            parity;
   logic            bit_end;
   logic            unused_flags;

   assign bit_end      = (baud == BAUD_LAST);
   // Only the Empty flag matters; the remaining flags are deliberately ignored.
   assign unused_flags = ^Fifo_Status[3:1];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         parity  <= 1'b0;
         Read    <= 1'b0;
         Tx      <= 1'b1;
         Busy    <= 1'b0;
         Tx_Done <= 1'b0;
      end else begin
         Read    <= 1'b0;
         Tx_Done <= 1'b0;
         baud    <= bit_end ? '0 : baud + 1'b1;
         case (state)
            IDLE: begin
               baud <= '0;
               Tx   <= 1'b1;
               if (Enable && !Fifo_Status[0]) begin
                  state <= FETCH;
                  Read  <= 1'b1;
                  Busy  <= 1'b1;
               end
            end
            FETCH: begin
               baud  <= '0;
               state <= LOAD;
            end
            LOAD: begin
               baud    <= '0;
               shift   <= Fifo_Data;
               parity  <= (^Fifo_Data) ^ PAR_ODD;
               bit_cnt <= '0;
               Tx      <= 1'b0;
               state   <= START;
            end
            START: begin
               if (bit_end) begin
                  Tx    <= shift[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift <= {1'b0, shift[7:1]};
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        Tx    <= parity;
                        state <= PARITY;
                     end else begin
                        Tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     Tx      <= shift[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  Tx    <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               // Registered pulse: arm one cycle early so it lands on the final stop cycle.
               if (bit_cnt == STOP_LAST && baud == BAUD_PENULT)
                  Tx_Done <= 1'b1;
               if (bit_end) begin
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     Busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               Tx    <= 1'b1;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench: default, even-parity and odd-parity/2-stop instances fed by small FIFO models.
module tb_uart_tx_fifo_drain;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic Reset;
   logic Enable;
   logic [1:0] sel;
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // default-instance FIFO model with registered Data_Out
   logic [7:0] mem [0:15];
   int         wr_d = 0;
   int         rd_d = 0;
   int         read_t [0:15];
   logic [7:0] dout_d;
   logic [3:0] st_d;
   logic       read_d, tx_d, busy_d, done_d;

   int         req_pe = 0, ack_pe = 0, req_po = 0, ack_po = 0;
   logic [7:0] dat_p;
   logic [3:0] st_pe, st_po;
   logic       read_pe, tx_pe, busy_pe, done_pe;
   logic       read_po, tx_po, busy_po, done_po;

   logic tx_s, done_s, busy_s;

   assign dat_p  = 8'h07;
   assign st_d   = {2'b00, ((wr_d - rd_d) <= 1), (wr_d == rd_d)};
   assign st_pe  = {3'b000, (req_pe == ack_pe)};
   assign st_po  = {3'b000, (req_po == ack_po)};
   assign tx_s   = (sel == 2'd0) ? tx_d   : (sel == 2'd1) ? tx_pe   : tx_po;
   assign done_s = (sel == 2'd0) ? done_d : (sel == 2'd1) ? done_pe : done_po;
   assign busy_s = (sel == 2'd0) ? busy_d : (sel == 2'd1) ? busy_pe : busy_po;

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (read_d) begin
         dout_d               <= mem[rd_d[3:0]];
         read_t[rd_d[3:0]]    <= cyc;
         rd_d                 <= rd_d + 1;
      end
      if (read_pe) ack_pe <= ack_pe + 1;
      if (read_po) ack_po <= ack_po + 1;
   end

   uart_tx_fifo_drain u_def (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Fifo_Status(st_d), .Fifo_Data(dout_d),
      .Read(read_d), .Tx(tx_d), .Busy(busy_d), .Tx_Done(done_d));

   uart_tx_fifo_drain #(.PARITY_EN(1)) u_pe (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Fifo_Status(st_pe), .Fifo_Data(dat_p),
      .Read(read_pe), .Tx(tx_pe), .Busy(busy_pe), .Tx_Done(done_pe));

   uart_tx_fifo_drain #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_po (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Fifo_Status(st_po), .Fifo_Data(dat_p),
      .Read(read_po), .Tx(tx_po), .Busy(busy_po), .Tx_Done(done_po));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_fall(input string tag, output int t);
      int n;
      n = 0;
      while (tx_s !== 1'b0 && n < 400) begin
         tick(1);
         n++;
      end
      t = cyc;
      check(tag, {31'd0, tx_s}, 32'd0);
   endtask

   // Walks one frame starting at the Tx fall; returns mid-bit samples and Tx_Done/Busy timing.
   task automatic run_frame(input int nbits, input int stop_from, input int drop_at,
                            output logic [11:0] bits, output int done_at, output int done_n,
                            output int stop_hi, output logic busy_last, output logic busy_after);
      bits      = '0;
      done_at   = -1;
      done_n    = 0;
      stop_hi   = 0;
      busy_last = 1'b0;
      for (int c = 0; c < nbits * 16; c++) begin
         if (c == drop_at) Enable = 1'b0;
         if (c % 16 == 8) bits[c / 16] = tx_s;
         if (done_s === 1'b1) begin
            done_n++;
            if (done_at < 0) done_at = c;
         end
         if (c >= stop_from && tx_s === 1'b1) stop_hi++;
         if (c == nbits * 16 - 1) busy_last = busy_s;
         tick(1);
      end
      busy_after = busy_s;
   endtask

   initial begin
      int         t0, done_at, done_n, stop_hi, viol;
      logic [11:0] bits;
      logic        bl, ba;
      logic [9:0]  exp10;

      Reset  = 1'b1;
      Enable = 1'b0;
      sel    = 2'd0;
      tick(5);
      Reset = 1'b0;
      check("rst_tx",   {31'd0, tx_d},   32'd1);
      check("rst_read", {31'd0, read_d}, 32'd0);
      check("rst_busy", {31'd0, busy_d}, 32'd0);
      check("rst_done", {31'd0, done_d}, 32'd0);

      viol = 0;
      for (int i = 0; i < 500; i++) begin
         if (tx_d !== 1'b1 || read_d !== 1'b0 || busy_d !== 1'b0) viol++;
         tick(1);
      end
      check("empty_quiet", viol, 0);
      Enable = 1'b1;
      tick(20);
      check("empty_no_read", rd_d, 0);
      check("empty_tx_high", {31'd0, tx_d}, 32'd1);

      // single byte A5
      mem[0] = 8'hA5;
      wr_d   = 1;
      wait_fall("a5_fall", t0);
      check("a5_latency", t0 - read_t[0], 2);
      run_frame(10, 144, -1, bits, done_at, done_n, stop_hi, bl, ba);
      exp10 = {1'b1, 8'hA5, 1'b0};
      check("a5_bits", {22'd0, bits[9:0]}, {22'd0, exp10});
      check("a5_done_at", done_at, 159);
      check("a5_done_n", done_n, 1);
      check("a5_stop_hi", stop_hi, 16);
      check("a5_busy_last", {31'd0, bl}, 32'd1);
      check("a5_busy_after", {31'd0, ba}, 32'd0);
      check("a5_reads", rd_d, 1);

      // three back-to-back bytes
      mem[1] = 8'h01;
      mem[2] = 8'h02;
      mem[3] = 8'h03;
      wr_d   = 4;
      for (int k = 0; k < 3; k++) begin
         wait_fall("b2b_fall", t0);
         run_frame(10, 144, -1, bits, done_at, done_n, stop_hi, bl, ba);
         check("b2b_byte", {24'd0, bits[8:1]}, k + 1);
         check("b2b_done_at", done_at, 159);
      end
      tick(300);
      check("b2b_reads", rd_d, 4);
      check("b2b_empty", {31'd0, st_d[0]}, 32'd1);
      check("b2b_gap1", read_t[2] - read_t[1], 163);
      check("b2b_gap2", read_t[3] - read_t[2], 163);

      // even parity, 8'h07
      sel    = 2'd1;
      req_pe = 1;
      wait_fall("pe_fall", t0);
      run_frame(11, 160, -1, bits, done_at, done_n, stop_hi, bl, ba);
      check("pe_data", {24'd0, bits[8:1]}, 32'h07);
      check("pe_parity", {31'd0, bits[9]}, 32'd1);
      check("pe_stop", {31'd0, bits[10]}, 32'd1);
      check("pe_done_at", done_at, 175);
      tick(50);
      check("pe_reads", ack_pe, 1);

      // odd parity, two stop bits
      sel    = 2'd2;
      req_po = 1;
      wait_fall("po_fall", t0);
      run_frame(12, 160, -1, bits, done_at, done_n, stop_hi, bl, ba);
      check("po_data", {24'd0, bits[8:1]}, 32'h07);
      check("po_parity", {31'd0, bits[9]}, 32'd0);
      check("po_stop_hi", stop_hi, 32);
      check("po_done_at", done_at, 191);
      check("po_busy_after", {31'd0, ba}, 32'd0);
      tick(50);
      check("po_reads", ack_po, 1);

      // reset in the middle of a frame (cycle 50 sits in a 0 data bit of 3A)
      sel    = 2'd0;
      mem[4] = 8'h3A;
      wr_d   = 5;
      wait_fall("rm_fall", t0);
      tick(50);
      check("rm_pre_tx", {31'd0, tx_d}, 32'd0);
      Reset = 1'b1;
      tick(1);
      check("rm_tx", {31'd0, tx_d}, 32'd1);
      check("rm_busy", {31'd0, busy_d}, 32'd0);
      check("rm_read", {31'd0, read_d}, 32'd0);
      Reset = 1'b0;
      tick(300);
      check("rm_no_read", rd_d, 5);
      check("rm_tx_idle", {31'd0, tx_d}, 32'd1);

      // Enable dropped mid-frame with more data waiting
      mem[5] = 8'h55;
      mem[6] = 8'h66;
      wr_d   = 7;
      wait_fall("en_fall", t0);
      run_frame(10, 144, 40, bits, done_at, done_n, stop_hi, bl, ba);
      check("en_byte", {24'd0, bits[8:1]}, 32'h55);
      check("en_done_at", done_at, 159);
      tick(300);
      check("en_hold", rd_d, 6);
      check("en_hold_tx", {31'd0, tx_d}, 32'd1);
      Enable = 1'b1;
      wait_fall("en_resume_fall", t0);
      run_frame(10, 144, -1, bits, done_at, done_n, stop_hi, bl, ba);
      check("en_resume_byte", {24'd0, bits[8:1]}, 32'h66);
      check("en_resume_reads", rd_d, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Transmit-side consumer of the UART TX FIFO (`Fifo_variable`). It watches `Fifo_Status` and pulses `Read` one byte at a time while the FIFO is non-empty. Each byte is serialized onto the line as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. It sits between the TX FIFO's read port and the UART `Tx` pin, and is the reader-side counterpart to whatever fills the FIFO.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: `Clk` cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `Clk`  in  1  single clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Enable`  in  1  1 = allowed to start new frames.
- `Fifo_Status`  in  4  FIFO flags: [0] Empty, [1] Almost empty, [2] Almost full, [3] Full (same masks as `uart_defines.v`).
- `Fifo_Data`  in  8  FIFO `Data_Out`; valid the cycle after a `Read` pulse.
- `Read`  out  1  one-cycle FIFO pop strobe.
- `Tx`  out  1  serial line; idle high.
- `Busy`  out  1  high from FETCH through the end of the last stop bit.
- `Tx_Done`  out  1  one-cycle pulse on the final cycle of the last stop bit.

## Operation

- Reset values: `Read`=0, `Tx`=1, `Busy`=0, `Tx_Done`=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Only `Fifo_Status[0]` (Empty) gates reads. The other flags are ignored.

States and transitions:
- IDLE: `Tx`=1. Go to FETCH if `Enable`=1 and Empty=0.
- FETCH: `Read`=1 for exactly this cycle. Go to LOAD.
- LOAD: capture `Fifo_Data` into the shift register and compute parity (XOR of the 8 bits, inverted if `PARITY_ODD`). Go to START.
- START: `Tx`=0 for `CLKS_PER_BIT` cycles. Go to DATA.
- DATA: `Tx`=shift[0]. Shift right every `CLKS_PER_BIT` cycles. After 8 bits, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `Tx`=parity bit for one bit period. Go to STOP.
- STOP: `Tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. `Tx_Done` pulses on the last cycle. Go to IDLE.

Baud counter:
- Counts 0..`CLKS_PER_BIT`-1.
- Clears on entry to START and at each bit boundary.
- Width is `$clog2(CLKS_PER_BIT)`, minimum 1 bit.

Boundary behaviour:
- FIFO empty: never pulse `Read`; `Tx` stays 1 indefinitely.
- `Enable` deasserted mid-frame: the current frame completes normally; no new FETCH follows.
- `Reset` mid-frame: on the next edge all outputs return to reset values. The in-flight byte is lost and no `Read` is issued.
- `Fifo_Status` changes during a frame: ignored; flags are sampled only in IDLE.
- A single FIFO entry yields exactly one `Read` pulse. The FETCH→LOAD→START sequence gives the FIFO status time to update before the next IDLE sample, so no double pop occurs.

## Timing

- Start latency: IDLE sampling Empty=0 at edge N gives `Read`=1 in cycle N+1, data capture at N+2, and `Tx` falls at N+3.
- Frame length: (1 + 8 + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, counted from the `Tx` fall.
  - Default configuration: 160 cycles.
- Back-to-back frames: with Empty=0 continuously, the gap between consecutive frames is 3 cycles (IDLE, FETCH, LOAD), with `Tx`=1 throughout.
  - Inter-frame period at defaults: 163 cycles.
- `Busy` rises with `Read` and falls the cycle after `Tx_Done`.

## Test plan

- Reset with `Fifo_Status`=4'b0001: `Tx`=1, `Read`=0, `Busy`=0 for 500 cycles. Release `Enable`=1; still no `Read`.
- Single byte 8'hA5, defaults: exactly one `Read` pulse. `Tx` shows 0, then 1,0,1,0,0,1,0,1, then 1. Each bit is 16 cycles. `Tx_Done` fires at cycle 160 after the `Tx` fall.
- Three bytes 8'h01, 8'h02, 8'h03 from a model FIFO with the registered `Data_Out`: three `Read` pulses spaced 163 cycles apart. The decoded bytes match in order. Empty asserts after the third pop and no fourth `Read` occurs.
- `PARITY_EN`=1, `PARITY_ODD`=0, byte 8'h07: parity bit = 1. With `PARITY_ODD`=1: parity bit = 0. With `STOP_BITS`=2: stop high for 32 cycles and frame length 192 cycles.
- `Reset` asserted at cycle 50 of a frame: `Tx`=1 and `Busy`=0 on the next edge. After release with Empty=1, no `Read` occurs.
- `Enable` dropped mid-frame with FIFO non-empty: the frame finishes with `Tx_Done`, then no further `Read` until `Enable`=1.
